// File: rtl/fir_tap_loader.sv
// Coefficient reload sequencer for the adjustable-tap FIR: serialises a valid/ready stream into the tap chain.
// Build option FIRLOAD_SYMMETRIC_EN: load half the taps and replay them mirrored.
module fir_tap_loader #(
    parameter int NTAPS = 128,
    parameter int TW    = 12,
    parameter int CW    = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_coef_valid,
    output logic          o_coef_ready,
    input  logic [TW-1:0] i_coef,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    input  logic          i_ce,
    output logic          o_ce,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_count
);

    // state    | meaning
    // UNLOADED | tap contents unknown, waiting for i_start
    // LOAD     | accepting coefficients, one tap strobe per handshake
    // REPLAY   | mirrored half replayed from the buffer (symmetric build only)
    // SETTLE   | counting i_ce until old-tap partial sums have flushed
    // RUN      | taps stable, o_result trustworthy
    typedef enum logic [2:0] {
        ST_UNLOADED,
        ST_LOAD,
        ST_REPLAY,
        ST_SETTLE,
        ST_RUN
    } state_t;

`ifdef FIRLOAD_SYMMETRIC_EN
    localparam int NLOAD = NTAPS / 2;
`else
    localparam int NLOAD = NTAPS;
`endif
    localparam logic [CW-1:0] LOAD_N      = CW'(NLOAD);
    localparam logic [CW-1:0] LOAD_LAST   = CW'(NLOAD - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(NTAPS + 1);
    localparam logic [CW-1:0] COUNT_MAX   = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tap_q, tap_d;
    logic          tap_wr_q, tap_wr_d;
    logic          done_q, done_d;
    logic          coef_ready;
    logic          hs;
    logic          loading;

`ifdef FIRLOAD_SYMMETRIC_EN
    localparam int BW = (NLOAD > 1) ? $clog2(NLOAD) : 1;
    localparam logic [CW-1:0] TAPS_LAST = CW'(NTAPS - 1);

    logic [TW-1:0] coef_buf_q [NLOAD];
    logic [TW-1:0] coef_buf_d [NLOAD];
    logic [BW-1:0] wr_idx, rd_idx;

    assign wr_idx = BW'(count_q);
    // Replay walks the buffer backwards: strobe NTAPS-1-k carries h[k].
    assign rd_idx = BW'(TAPS_LAST - count_q);

    always_ff @(posedge i_clk) begin
        coef_buf_q <= coef_buf_d;
    end
`endif

    assign coef_ready = (state_q == ST_LOAD) && (count_q < LOAD_N);
    assign hs         = i_coef_valid & coef_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tap_d    = tap_q;
        tap_wr_d = 1'b0;
        done_d   = 1'b0;
`ifdef FIRLOAD_SYMMETRIC_EN
        coef_buf_d = coef_buf_q;
`endif
        case (state_q)
            ST_UNLOADED: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    tap_d    = i_coef;
                    tap_wr_d = 1'b1;
                    count_d  = count_q + CW'(1);
`ifdef FIRLOAD_SYMMETRIC_EN
                    coef_buf_d[wr_idx] = i_coef;
                    if (count_q == LOAD_LAST) state_d = ST_REPLAY;
`else
                    if (count_q == LOAD_LAST) begin
                        state_d = ST_SETTLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef FIRLOAD_SYMMETRIC_EN
            ST_REPLAY: begin
                tap_d    = coef_buf_q[rd_idx];
                tap_wr_d = 1'b1;
                count_d  = count_q + CW'(1);
                if (count_q == TAPS_LAST) begin
                    state_d = ST_SETTLE;
                    count_d = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_SETTLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end else if (i_ce) begin
                    if (count_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else if (count_q != COUNT_MAX) begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_UNLOADED;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_UNLOADED;
            count_q  <= '0;
            tap_q    <= '0;
            tap_wr_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tap_q    <= tap_d;
            tap_wr_q <= tap_wr_d;
            done_q   <= done_d;
        end
    end

    // Samples stay frozen while taps shift so the delay line never mixes coefficient sets.
    assign loading      = (state_q == ST_LOAD) || (state_q == ST_REPLAY);
    assign o_ce         = i_ce & ~loading;
    assign o_busy       = loading || (state_q == ST_SETTLE);
    assign o_valid      = i_ce & (state_q == ST_RUN);
    assign o_coef_ready = coef_ready;
    assign o_tap_wr     = tap_wr_q;
    assign o_tap        = tap_q;
    assign o_done       = done_q;
    assign o_count      = count_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader (NTAPS=8); models the FIR tap chain to check final tap order.
module tb_fir_tap_loader;
    localparam int NTAPS = 8;
    localparam int TW    = 12;
    localparam int CW    = 8;

    logic          i_clk = 1'b0;
    logic          i_reset, i_start, i_coef_valid, i_ce;
    logic [TW-1:0] i_coef;
    logic          o_coef_ready, o_tap_wr, o_ce, o_valid, o_busy, o_done;
    logic [TW-1:0] o_tap;
    logic [CW-1:0] o_count;

    int errors = 0;
    int checks = 0;

    int n_strobes, n_done, done_last;

    fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .CW(CW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_coef_valid(i_coef_valid), .o_coef_ready(o_coef_ready), .i_coef(i_coef),
        .o_tap_wr(o_tap_wr), .o_tap(o_tap), .i_ce(i_ce), .o_ce(o_ce),
        .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural FIR tap chain: new taps enter at the top and shift toward stage 0.
    logic [TW-1:0] chain [NTAPS];
    always @(posedge i_clk) begin
        if (o_tap_wr) begin
            for (int i = 0; i < NTAPS - 1; i++) chain[i] <= chain[i + 1];
            chain[NTAPS - 1] <= o_tap;
        end
    end

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    // Stimulus only: i_start, then NTAPS back-to-back coefficients base+k, i_start
    // re-asserted alongside handshake start_at (-1 for never); records strobes/done.
    task automatic load_seq(input int base, input int start_at);
        n_strobes = 0; n_done = 0; done_last = 0;
        i_start = 1'b1; #1; step;
        i_start = 1'b0;
        for (int k = 0; k <= NTAPS; k++) begin
            i_coef_valid = (k < NTAPS);
            i_coef       = TW'(base + k);
            i_start      = (k == start_at);
            #1;
            if (o_tap_wr) n_strobes++;
            if (o_done) begin n_done++; done_last = (k == NTAPS) && o_tap_wr; end
            step;
        end
        i_start = 1'b0; i_coef_valid = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_start = 1'b0; i_coef_valid = 1'b0; i_ce = 1'b0; i_coef = '0;
        step; step;
        i_reset = 1'b0; i_ce = 1'b1; i_coef_valid = 1'b1; i_coef = 12'h5a5;
        #1;
        checks++; if ({o_done, o_tap, o_count} !== '0) begin errors++;
            $display("FAIL reset_regs done/tap/count=%0d/%0d/%0d want 0/0/0", o_done, o_tap, o_count); end
        for (int c = 0; c < 20; c++) begin
            checks++; if ({o_valid, o_busy, o_tap_wr, o_coef_ready, o_ce} !== 5'b00001) begin errors++;
                $display("FAIL idle_outputs cycle %0d valid/busy/wr/ready/ce=%b want 00001", c,
                         {o_valid, o_busy, o_tap_wr, o_coef_ready, o_ce}); end
            step;
        end
        i_coef_valid = 1'b0;
    endtask

    task automatic test_load;
        i_ce = 1'b1; i_start = 1'b1; #1; step;
        i_start = 1'b0; i_coef_valid = 1'b1;
        for (int k = 1; k <= NTAPS; k++) begin
            i_coef = TW'(k); #1;
            checks++; if ({o_coef_ready, o_ce, o_busy, o_done} !== 4'b1010) begin errors++;
                $display("FAIL load_ctrl k=%0d ready/ce/busy/done=%b want 1010", k,
                         {o_coef_ready, o_ce, o_busy, o_done}); end
            checks++; if (o_count !== CW'(k - 1)) begin errors++;
                $display("FAIL load_count k=%0d got %0d want %0d", k, o_count, k - 1); end
            checks++; if (o_tap_wr !== (k > 1) || (k > 1 && o_tap !== TW'(k - 1))) begin errors++;
                $display("FAIL load_strobe k=%0d wr=%0d tap=%0d want wr=%0d tap=%0d", k, o_tap_wr, o_tap, k > 1, k - 1); end
            step;
        end
        i_coef_valid = 1'b0; #1;
        checks++; if ({o_tap_wr, o_done, o_coef_ready} !== 3'b110 || o_tap !== TW'(NTAPS)) begin errors++;
            $display("FAIL last_strobe wr/done/ready=%b tap=%0d want 110 tap=%0d",
                     {o_tap_wr, o_done, o_coef_ready}, o_tap, NTAPS); end
        for (int c = 1; c <= NTAPS + 2; c++) begin
            checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_count !== CW'(c - 1)) begin errors++;
                $display("FAIL settle cycle %0d valid=%0d busy=%0d count=%0d want 0 1 %0d", c, o_valid, o_busy, o_count, c - 1); end
            step;
        end
        checks++; if ({o_valid, o_busy, o_ce} !== 3'b101 || o_count !== '0) begin errors++;
            $display("FAIL run_entry valid/busy/ce=%b count=%0d want 101 0", {o_valid, o_busy, o_ce}, o_count); end
        for (int k = 0; k < NTAPS; k++) begin
            checks++; if (chain[k] !== TW'(k + 1)) begin errors++;
                $display("FAIL impulse_tap[%0d] got %0d want %0d", k, chain[k], k + 1); end
        end
    endtask

    task automatic test_toggle;
        int acc, strobes, j;
        i_ce = 1'b1; i_start = 1'b1; #1; step;
        i_start = 1'b0; acc = 0; strobes = 0; j = 0;
        while (acc < NTAPS && j < 40) begin
            i_coef_valid = (j % 2 == 0);
            i_coef = TW'(17 + acc); #1;
            checks++; if (o_count !== CW'(acc) || o_ce !== 1'b0) begin errors++;
                $display("FAIL toggle_count j=%0d count=%0d ce=%0d want %0d 0", j, o_count, o_ce, acc); end
            checks++; if (o_tap_wr !== (j % 2 == 1) || (o_tap_wr && o_tap !== TW'(16 + acc))) begin errors++;
                $display("FAIL toggle_strobe j=%0d wr=%0d tap=%0d want wr=%0d tap=%0d", j, o_tap_wr, o_tap, j % 2, 16 + acc); end
            if (o_tap_wr) strobes++;
            if (i_coef_valid) acc++;
            step; j++;
        end
        i_coef_valid = 1'b0; #1;
        checks++; if (j >= 40) begin errors++; $display("FAIL toggle_timeout acc=%0d want %0d", acc, NTAPS); end
        if (o_tap_wr) strobes++;
        checks++; if (o_done !== 1'b1 || strobes !== NTAPS) begin errors++;
            $display("FAIL toggle_total strobes=%0d done=%0d want %0d 1", strobes, o_done, NTAPS); end
        step;
        for (int k = 0; k < NTAPS; k++) begin
            checks++; if (chain[k] !== TW'(17 + k)) begin errors++;
                $display("FAIL toggle_tap[%0d] got %0d want %0d", k, chain[k], 17 + k); end
        end
    endtask

    task automatic test_reset_mid_load;
        i_start = 1'b1; #1; step;
        i_start = 1'b0; i_coef_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin i_coef = TW'(100 + k); #1; step; end
        i_coef_valid = 1'b0; i_reset = 1'b1; #1;
        checks++; if (o_count !== CW'(3) || o_tap_wr !== 1'b1) begin errors++;
            $display("FAIL partial_load count=%0d wr=%0d want 3 1", o_count, o_tap_wr); end
        step; i_reset = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({o_tap_wr, o_busy, o_coef_ready, o_valid} !== 4'b0000 || o_count !== '0) begin errors++;
                $display("FAIL after_reset cycle %0d wr/busy/ready/valid=%b count=%0d want 0000 0", c,
                         {o_tap_wr, o_busy, o_coef_ready, o_valid}, o_count); end
            step;
        end
        load_seq(200, -1);
        checks++; if (n_strobes !== NTAPS || n_done !== 1 || done_last !== 1) begin errors++;
            $display("FAIL reload strobes=%0d done=%0d last=%0d want %0d 1 1", n_strobes, n_done, done_last, NTAPS); end
        for (int k = 0; k < NTAPS; k++) begin
            checks++; if (chain[k] !== TW'(200 + k)) begin errors++;
                $display("FAIL reload_tap[%0d] got %0d want %0d", k, chain[k], 200 + k); end
        end
    endtask

    task automatic test_start_during_load;
        load_seq(300, 4);
        checks++; if (n_strobes !== NTAPS || n_done !== 1 || done_last !== 1 || o_coef_ready !== 1'b0) begin errors++;
            $display("FAIL start_mid_load strobes=%0d done=%0d last=%0d ready=%0d want %0d 1 1 0",
                     n_strobes, n_done, done_last, o_coef_ready, NTAPS); end
        load_seq(400, NTAPS - 1);
        checks++; if (n_strobes !== NTAPS || n_done !== 1 || o_coef_ready !== 1'b0 || o_busy !== 1'b1) begin errors++;
            $display("FAIL start_on_last strobes=%0d done=%0d ready=%0d busy=%0d want %0d 1 0 1",
                     n_strobes, n_done, o_coef_ready, o_busy, NTAPS); end
        step; step;
        checks++; if (o_count !== CW'(3)) begin errors++;
            $display("FAIL settle_progress count=%0d want 3", o_count); end
        i_start = 1'b1; #1; step; i_start = 1'b0; #1;
        checks++; if (o_count !== '0 || {o_coef_ready, o_busy, o_ce} !== 3'b110) begin errors++;
            $display("FAIL settle_restart count=%0d ready/busy/ce=%b want 0 110", o_count, {o_coef_ready, o_busy, o_ce}); end
        i_coef_valid = 1'b1;
        for (int k = 0; k < NTAPS - 1; k++) begin i_coef = TW'(500 + k); #1; step; end
        i_coef_valid = 1'b0; #1;
        checks++; if (o_done !== 1'b0 || o_coef_ready !== 1'b1 || o_count !== CW'(NTAPS - 1)) begin errors++;
            $display("FAIL restart_needs_all done=%0d ready=%0d count=%0d want 0 1 %0d", o_done, o_coef_ready, o_count, NTAPS - 1); end
        i_coef_valid = 1'b1; i_coef = TW'(500 + NTAPS - 1); #1; step;
        i_coef_valid = 1'b0; #1;
        checks++; if (o_done !== 1'b1 || o_tap !== TW'(500 + NTAPS - 1)) begin errors++;
            $display("FAIL restart_done done=%0d tap=%0d want 1 %0d", o_done, o_tap, 500 + NTAPS - 1); end
        step;
    endtask

`ifdef FIRLOAD_SYMMETRIC_EN
    task automatic test_symmetric;
        logic [TW-1:0] exp_sym [NTAPS];
        logic [TW-1:0] got [16];
        int ns, done_at;
        exp_sym = '{5, 6, 7, 8, 8, 7, 6, 5};
        ns = 0; done_at = -1;
        i_start = 1'b1; #1; step; i_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            i_coef_valid = 1'b1;
            i_coef = (c < NTAPS / 2) ? TW'(5 + c) : TW'(99);
            #1;
            if (c >= NTAPS / 2 && c <= NTAPS) begin
                checks++; if (o_coef_ready !== 1'b0) begin errors++;
                    $display("FAIL replay_ready cycle %0d got %0d want 0", c, o_coef_ready); end
            end
            if (o_tap_wr && ns < 16) begin got[ns] = o_tap; ns++; end
            if (o_done) done_at = ns;
            step;
        end
        i_coef_valid = 1'b0;
        checks++; if (ns !== NTAPS || done_at !== NTAPS) begin errors++;
            $display("FAIL sym_strobes count=%0d done_at=%0d want %0d %0d", ns, done_at, NTAPS, NTAPS); end
        for (int k = 0; k < NTAPS; k++) begin
            checks++; if (k >= ns || got[k] !== exp_sym[k]) begin errors++;
                $display("FAIL sym_strobe[%0d] got %0d want %0d", k, (k < ns) ? got[k] : 0, exp_sym[k]); end
            checks++; if (chain[k] !== exp_sym[k]) begin errors++;
                $display("FAIL sym_tap[%0d] got %0d want %0d", k, chain[k], exp_sym[k]); end
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef FIRLOAD_SYMMETRIC_EN
        test_symmetric;
`else
        test_load;
        test_toggle;
        test_reset_mid_load;
        test_start_during_load;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
